// File: rtl/text_mem_write_scheduler.sv
// Text memory write-port arbiter: UART character writes versus a full-screen clear.
// UART writes arriving during a clear are deferred through a small FIFO and issued afterwards.
module text_mem_write_scheduler #(
  parameter int unsigned COLS       = 80,
  parameter int unsigned ROWS       = 30,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  uart_data,
  input  logic [12:0] uart_address,
  input  logic        uart_write,
  input  logic        clear_start,
  input  logic [7:0]  clear_char,
  input  logic        overflow_clear,
  output logic [7:0]  mem_data,
  output logic [12:0] mem_address,
  output logic        mem_write,
  output logic        clear_busy,
  output logic        overflow
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  COL_LIM  = 8'(COLS);
  localparam logic [4:0]  ROW_LIM  = 5'(ROWS);
  localparam logic [7:0]  COL_LAST = 8'(COLS - 1);
  localparam logic [4:0]  ROW_LAST = 5'(ROWS - 1);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, CLEAR, DRAIN} state_t;

  state_t      state;
  logic [7:0]  col;
  logic [4:0]  row;
  logic [7:0]  fill_char;
  logic [20:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  logic uart_valid;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic drop;
  logic last_cell;

  always_comb begin
    uart_valid = uart_write && (uart_address[7:0] < COL_LIM) && (uart_address[12:8] < ROW_LIM);
    full       = (count == FULL_CNT);
    empty      = (count == '0);
    pop        = (state == DRAIN) && !empty;
    // A full FIFO still accepts a push when the same cycle pops an entry.
    push       = uart_valid && (state != IDLE) && (!full || pop);
    drop       = uart_valid && (state != IDLE) && full && !pop;
    last_cell  = (row == ROW_LAST) && (col == COL_LAST);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      fill_char   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      mem_data    <= '0;
      mem_address <= '0;
      mem_write   <= 1'b0;
      clear_busy  <= 1'b0;
      overflow    <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      mem_write <= 1'b0;

      if (push) begin
        fifo_q[wr_ptr] <= {uart_data, uart_address};
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (drop) overflow <= 1'b1;
      else if (overflow_clear) overflow <= 1'b0;

      case (state)
        IDLE: begin
          if (uart_valid) begin
            mem_write   <= 1'b1;
            mem_address <= uart_address;
            mem_data    <= uart_data;
          end
          if (clear_start) begin
            fill_char  <= clear_char;
            row        <= '0;
            col        <= '0;
            state      <= CLEAR;
            clear_busy <= 1'b1;
          end
        end

        CLEAR: begin
          mem_write   <= 1'b1;
          mem_address <= {row, col};
          mem_data    <= fill_char;
          if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
          // A push on the final fill cycle must still be drained.
          if (last_cell) begin
            if (!empty || push) begin
              state <= DRAIN;
            end else begin
              state      <= IDLE;
              clear_busy <= 1'b0;
            end
          end
        end

        DRAIN: begin
          if (!empty) begin
            mem_write   <= 1'b1;
            mem_address <= fifo_q[rd_ptr][12:0];
            mem_data    <= fifo_q[rd_ptr][20:13];
          end
          if (empty || (count == (PW + 1)'(1) && !push)) begin
            state      <= IDLE;
            clear_busy <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          clear_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
